// File: rtl/color_pwm_if.sv
// rtl/color_pwm_if.sv - colour-index handshake between the colour sequencer and color_pwm
//
// Signals:
//   color        palette index offered by the sequencer (0..15)
//   color_valid  color is valid this cycle
//   color_ready  color_pwm can accept color this cycle
// Modports:
//   master  sequencer side (drives color/color_valid)
//   slave   color_pwm side (drives color_ready)
interface color_pwm_if;
    logic [3:0] color;
    logic       color_valid;
    logic       color_ready;

    modport master (output color, output color_valid, input color_ready);
    modport slave  (input color, input color_valid, output color_ready);
endinterface

// File: rtl/color_pwm.sv
// rtl/color_pwm.sv - three-channel palette PWM LED driver with period-aligned colour updates
//
// Parameters:
//   PRESCALE   clk cycles per PWM tick (1..65535)
//   PWM_BITS   PWM counter / duty width (2..12)
//   FADE_STEP  duty change per period while fading (1..2^PWM_BITS-1)
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   cin          colour handshake (color_pwm_if.slave)
//   led_r/g/b    registered PWM outputs
//   period_done  one-cycle pulse the cycle after each period wrap
//   busy         an active duty differs from its target duty
// Build option:
//   COLOR_PWM_FADE_EN  when defined, active duties ramp toward the target by
//                      FADE_STEP per period instead of jumping.
module color_pwm #(
    parameter int PRESCALE  = 4,
    parameter int PWM_BITS  = 8,
    parameter int FADE_STEP = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    color_pwm_if.slave  cin,
    output logic        led_r,
    output logic        led_g,
    output logic        led_b,
    output logic        period_done,
    output logic        busy
);

    typedef logic [PWM_BITS-1:0]      duty_t;
    // Channel order inside a duty3_t: [2]=red, [1]=green, [0]=blue.
    typedef logic [2:0][PWM_BITS-1:0] duty3_t;

    localparam duty_t FULL = {PWM_BITS{1'b1}};
    localparam duty_t HALF = {1'b1, {(PWM_BITS-1){1'b0}}};
    localparam duty_t ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};
    localparam duty_t STEP = duty_t'(FADE_STEP);
    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    logic [15:0] presc;
    duty_t       cnt;
    logic        pend_valid;
    logic [3:0]  pend_idx;
    duty3_t      target;
    duty3_t      active;
    duty3_t      next_target;
    duty3_t      next_active;

    logic tick;
    logic wrap;
    logic transfer;

    function automatic duty3_t palette(input logic [3:0] idx);
        duty_t      lvl;
        logic [2:0] rgb;
        lvl = idx[3] ? HALF : FULL;
        case (idx[2:0])
            3'd0:    rgb = 3'b000;
            3'd1:    rgb = 3'b100;
            3'd2:    rgb = 3'b010;
            3'd3:    rgb = 3'b001;
            3'd4:    rgb = 3'b110;
            3'd5:    rgb = 3'b011;
            3'd6:    rgb = 3'b101;
            default: rgb = 3'b111;
        endcase
        return {rgb[2] ? lvl : '0, rgb[1] ? lvl : '0, rgb[0] ? lvl : '0};
    endfunction

    // Move cur one FADE_STEP toward tgt, landing exactly on tgt instead of
    // overshooting; differences are taken in the safe direction so nothing wraps.
    function automatic duty_t approach(input duty_t cur, input duty_t tgt);
        if (tgt > cur)
            return ((tgt - cur) <= STEP) ? tgt : cur + STEP;
        else if (cur > tgt)
            return ((cur - tgt) <= STEP) ? tgt : cur - STEP;
        else
            return cur;
    endfunction

    assign tick     = (presc == PS_LAST);
    assign wrap     = tick && (cnt == FULL);
    assign transfer = cin.color_valid && !pend_valid;

    assign cin.color_ready = !pend_valid;

    always_comb begin
        next_target = pend_valid ? palette(pend_idx) : target;
`ifdef COLOR_PWM_FADE_EN
        for (int i = 0; i < 3; i++)
            next_active[i] = approach(active[i], next_target[i]);
`else
        next_active = next_target;
`endif
    end

`ifdef COLOR_PWM_FADE_EN
    assign busy = (active != target);
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc       <= '0;
            cnt         <= '0;
            pend_valid  <= 1'b0;
            pend_idx    <= '0;
            target      <= '0;
            active      <= '0;
            led_r       <= 1'b0;
            led_g       <= 1'b0;
            led_b       <= 1'b0;
            period_done <= 1'b0;
        end else begin
            presc <= tick ? 16'd0 : presc + 16'd1;
            if (tick)
                cnt <= cnt + ONE;

            period_done <= wrap;

            // Duties only change at the wrap, so compare against the pre-wrap
            // values here; the new duty takes effect from counter 0.
            led_r <= (cnt < active[2]);
            led_g <= (cnt < active[1]);
            led_b <= (cnt < active[0]);

            // A transfer can only happen with pend_valid low, so it never
            // collides with the wrap consuming a pending colour.
            if (transfer) begin
                pend_valid <= 1'b1;
                pend_idx   <= cin.color;
            end else if (wrap) begin
                pend_valid <= 1'b0;
            end

            if (wrap) begin
                target <= next_target;
                active <= next_active;
            end
        end
    end

endmodule

// File: tb/tb_color_pwm.sv
// tb/tb_color_pwm.sv - self-checking bench for color_pwm (PWM_BITS=4, PRESCALE=1, FADE_STEP=4)
module tb_color_pwm;

    localparam int P     = 1;
    localparam int B     = 4;
    localparam int S     = 4;
    localparam int N     = 16;
    localparam int FULLV = 15;
    localparam int HALFV = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic led_r, led_g, led_b, period_done, busy;

    color_pwm_if cif();

    color_pwm #(.PRESCALE(P), .PWM_BITS(B), .FADE_STEP(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cin         (cif),
        .led_r       (led_r),
        .led_g       (led_g),
        .led_b       (led_b),
        .period_done (period_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference model: time is k edges since reset release; ch 0=r,1=g,2=b.
    int k = 0;
    bit m_pend = 0;
    int m_idx = 0;
    int m_act[3] = '{0, 0, 0};
    int m_tgt[3] = '{0, 0, 0};
    bit e_led[3] = '{0, 0, 0};
    bit e_pd = 0;
    int rgb_mask[8] = '{0, 4, 2, 1, 6, 3, 5, 7};

    int cnt_r, cnt_g, cnt_b, cnt_pd;

    function automatic int pal(input int idx, input int ch);
        int lvl;
        lvl = (idx >= 8) ? HALFV : FULLV;
        return ((rgb_mask[idx % 8] >> (2 - ch)) & 1) != 0 ? lvl : 0;
    endfunction

    function automatic int approach(input int cur, input int tgt);
        if (tgt > cur) return (cur + S > tgt) ? tgt : cur + S;
        if (cur > tgt) return (cur - S < tgt) ? tgt : cur - S;
        return cur;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input int c);
        int  cnt;
        bit  wrap, xfer;
        if (!r) begin
            k = 0; m_pend = 0; m_idx = 0; e_pd = 0;
            for (int i = 0; i < 3; i++) begin
                m_act[i] = 0; m_tgt[i] = 0; e_led[i] = 0;
            end
            return;
        end
        cnt  = (k / P) % N;
        wrap = ((k + 1) % (N * P)) == 0;
        xfer = v && !m_pend;
        for (int i = 0; i < 3; i++) e_led[i] = cnt < m_act[i];
        e_pd = wrap;
        if (wrap) begin
            for (int i = 0; i < 3; i++) begin
                if (m_pend) m_tgt[i] = pal(m_idx, i);
`ifdef COLOR_PWM_FADE_EN
                m_act[i] = approach(m_act[i], m_tgt[i]);
`else
                m_act[i] = m_tgt[i];
`endif
            end
            m_pend = 0;
        end
        if (xfer) begin
            m_pend = 1;
            m_idx  = c;
        end
        k++;
    endtask

    task automatic cycle(input bit v, input int c, input bit r);
        @(negedge clk);
        check("led_r", led_r, e_led[0]);
        check("led_g", led_g, e_led[1]);
        check("led_b", led_b, e_led[2]);
        check("period_done", period_done, e_pd);
        check("color_ready", cif.color_ready, !m_pend);
        check("busy", busy, (m_act[0] != m_tgt[0]) || (m_act[1] != m_tgt[1]) || (m_act[2] != m_tgt[2]));
        cnt_r  += led_r;
        cnt_g  += led_g;
        cnt_b  += led_b;
        cnt_pd += period_done;
        rst_n           = r;
        cif.color_valid = v;
        cif.color       = 4'(c);
        @(posedge clk);
        model_edge(r, v, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 1);
    endtask

    task automatic send(input int c);
        for (int i = 0; i < 200; i++) begin
            if (!m_pend) begin
                cycle(1, c, 1);
                return;
            end
            cycle(0, 0, 1);
        end
        check("send_timeout", 1, 0);
    endtask

    // Position so the next sample reflects counter 0 of a fresh period.
    task automatic align();
        for (int i = 0; i < 2 * N * P; i++) begin
            if (k % (N * P) == 1) return;
            cycle(0, 0, 1);
        end
        check("align_timeout", 1, 0);
    endtask

    task automatic count_period(input int n);
        cnt_r = 0; cnt_g = 0; cnt_b = 0; cnt_pd = 0;
        idle(n);
    endtask

    initial begin
        cif.color_valid = 1'b0;
        cif.color       = 4'd0;
        rst_n           = 1'b0;
        repeat (3) @(posedge clk);
        model_edge(0, 0, 0);

        // Reset state, then release.
        cycle(0, 0, 1);

        // Colour 1: red 15/16, others off, period_done every 16 cycles.
        send(1);
        idle(6 * N);
        align();
        count_period(N);
        check("c1_red_high", cnt_r, 15);
        check("c1_green_high", cnt_g, 0);
        check("c1_blue_high", cnt_b, 0);
        count_period(2 * N);
        check("c1_period_done", cnt_pd, 2);

        // Backpressure: 2 then 3 held valid.
        send(2);
        for (int i = 0; i < 60; i++) cycle(1, 3, 1);
        idle(6 * N);
        align();
        count_period(N);
        check("c3_blue_high", cnt_b, 15);
        check("c3_green_high", cnt_g, 0);

        // Half palette.
        send(12);
        idle(6 * N);
        align();
        count_period(N);
        check("c12_red_high", cnt_r, 8);
        check("c12_green_high", cnt_g, 8);
        check("c12_blue_high", cnt_b, 0);

        // Mid-period reset with white active and a colour pending.
        send(7);
        idle(6 * N);
        align();
        idle(5);
        cycle(1, 5, 1);
        cycle(0, 0, 0);
        idle(3 * N);
        align();
        count_period(N);
        check("rst_red_high", cnt_r, 0);
        check("rst_green_high", cnt_g, 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            cycle(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1);

`ifdef COLOR_PWM_FADE_EN
        // Fade 0 -> red: 4, 8, 12, 15 per period.
        cycle(0, 0, 0);
        send(1);
        while (m_pend) cycle(0, 0, 1);
        align();
        count_period(N);
        check("fade_p1", cnt_r, 4);
        count_period(N);
        check("fade_p2", cnt_r, 8);
        count_period(N);
        check("fade_p3", cnt_r, 12);
        count_period(N);
        check("fade_p4", cnt_r, 15);
        idle(2);
        check("fade_busy_done", busy, 0);
`endif

        idle(4);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/color_pwm.md
COLOR_PWM -- requirements
Module: color_pwm

Interface
REQ-001 Parameter PRESCALE, default 4, clk cycles per PWM tick; legal range 1 to 65535.
REQ-002 Parameter PWM_BITS, default 8, PWM counter and duty width; legal range 2 to 12.
REQ-003 Parameter FADE_STEP, default 16, duty change per period when fading; legal range 1 to 2^PWM_BITS-1.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 color  input  4  palette index offered by the upstream color sequencer.
REQ-007 color_valid  input  1  color is valid this cycle.
REQ-008 color_ready  output  1  block can accept color this cycle.
REQ-009 led_r, led_g, led_b  output  1 each  registered PWM drive outputs.
REQ-010 period_done  output  1  one-cycle pulse at each PWM period wrap.
REQ-011 busy  output  1  high while any active duty differs from its target duty.

Function
REQ-012 Prescaler counts 0..PRESCALE-1; tick asserts in the cycle the prescaler equals PRESCALE-1, then the prescaler wraps to 0.
REQ-013 PWM counter (PWM_BITS) increments on each tick; from 2^PWM_BITS-1 it wraps to 0, and that wrap tick is the period wrap.
REQ-014 period_done is registered: high exactly one cycle, the cycle after the period wrap tick.
REQ-015 Palette, with FULL = 2^PWM_BITS-1 and HALF = 2^(PWM_BITS-1); index 0 = (0,0,0); 1 = (F,0,0); 2 = (0,F,0); 3 = (0,0,F); 4 = (F,F,0); 5 = (0,F,F); 6 = (F,0,F); 7 = (F,F,F).
REQ-016 Indices 8..15 give the index-8 colour with every FULL replaced by HALF.
REQ-017 Single-entry pending register; color_ready = NOT pending_valid; a transfer occurs when color_valid and color_ready are both high.
REQ-018 On a transfer, color is stored in pending and pending_valid sets.
REQ-019 At a period wrap with pending_valid set, the target duties load from the palette entry of the pending index, and pending_valid clears.
REQ-020 A transfer in the same cycle as a period wrap is not bypassed: it is stored in pending and applied at the following wrap.
REQ-021 color is ignored while color_valid is low; color_valid held with color_ready low causes no state change.
REQ-022 Each led output is registered: high when the PWM counter is less than that channel's active duty, otherwise low; a duty of 0 gives a constant-low output.
REQ-023 Active duty changes only at a period wrap, so the new value applies from counter 0 and no period is truncated.
REQ-024 All duty arithmetic is unsigned, PWM_BITS wide, with no wrap-around past 0 or FULL.

Reset
REQ-025 While rst_n is sampled low, the following clear to 0: prescaler, PWM counter, pending_valid, pending index, target and active duties, led_r/g/b, period_done.
REQ-026 After reset, color_ready reads 1 and busy reads 0.
REQ-027 Reset asserted mid-period or mid-fade discards all state, including a pending colour; there is no partial-period completion.

Configuration
REQ-028 Macro COLOR_PWM_FADE_EN: when defined, at each period wrap each active duty moves toward its target, after any target load in the same wrap, by FADE_STEP, saturating exactly at the target.
REQ-029 Without COLOR_PWM_FADE_EN, active duty equals the target immediately at the loading wrap, and busy is tied to 0.

Verification
REQ-030 Reset: PWM_BITS=4, PRESCALE=1, rst_n low 3 cycles -> all leds 0, period_done 0, color_ready 1, busy 0.
REQ-031 Load: send color=1 -> color_ready drops; after next wrap led_r is high 15 of every 16 cycles, led_g and led_b stay 0; period_done pulses every 16 cycles.
REQ-032 Backpressure: send 2, then hold color=3 valid -> 3 accepted only in the cycle after the wrap that applies 2; 3 becomes active one period later.
REQ-033 Half palette: send 12 -> led_r and led_g high 8 of 16 cycles, led_b 0.
REQ-034 Mid-period reset with active duty 15 -> the cycle after the rst_n sample, leds 0, counter 0, pending cleared, color_ready 1.
REQ-035 With COLOR_PWM_FADE_EN, FADE_STEP=4, 0 to color=1 -> red duty goes 4, 8, 12, 15 on successive wraps; busy high until 15 is reached, then 0.
